yc_burst_scheduler: RTL

- Per-line and per-frame sequencer for the Y/C chroma encoder.
- Takes raw sync/blank timing plus the core's chroma configuration (phase increment, colorburst range, PAL flag) and produces:
  - a frame-aligned configuration snapshot;
  - the colorburst gate window;
  - the PAL V-switch line toggle;
  - a chroma-active qualifier.
- Sits between the core's video timing outputs and the chroma phase accumulator/modulator, so that configuration never changes mid-frame.

---
 rtl/yc_pkg.sv | 30 +++
 rtl/yc_sync_edge.sv | 28 ++
 rtl/yc_burst_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/yc_pkg.sv
// Shared types and field layout for the Y/C burst scheduler.
package yc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam int PHASE_INC_W = 40;
    localparam int RANGE_W     = 27;
    localparam int START_LSB   = 20;
    localparam int START_W     = 7;
    localparam int NTSC_LSB    = 10;
    localparam int NTSC_W      = 10;
    localparam int PAL_LSB     = 0;
    localparam int PAL_W       = 10;

    // A zero PAL end means the core supplied no PAL-specific window.
    function automatic logic [NTSC_W-1:0] end_select(input logic [RANGE_W-1:0] range,
                                                     input logic pal_sel);
        logic [NTSC_W-1:0] sel;
        sel = pal_sel ? range[PAL_LSB +: PAL_W] : range[NTSC_LSB +: NTSC_W];
        if (sel == '0) begin
            sel = range[NTSC_LSB +: NTSC_W];
        end
        return sel;
    endfunction

endpackage

// File: rtl/yc_sync_edge.sv
// Sync polarity normaliser with a leading-edge strobe and its registered pulse.
module yc_sync_edge #(
    parameter bit ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sync_in,
    output logic lead,
    output logic pulse
);

    logic level;
    logic level_d;

    assign level = ACTIVE_HIGH ? sync_in : ~sync_in;
    assign lead  = level & ~level_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= lead;
        end
    end

endmodule

// File: rtl/yc_burst_scheduler.sv
// Frame-aligned chroma config snapshot, burst gate and PAL V-switch sequencer.
//   state      | meaning
//   IDLE       | path disabled, gates forced low
//   WAIT_FRAME | enabled, waiting for the first vsync edge to snapshot config
//   RUN        | config valid, per-line burst and V-switch active
module yc_burst_scheduler
    import yc_pkg::*;
#(
    parameter bit HS_ACTIVE_HIGH    = 1'b1,
    parameter bit VS_ACTIVE_HIGH    = 1'b1,
    parameter int CNT_W             = 10,
    parameter bit SUPPRESS_VS_BURST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   yc_en,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   hblank,
    input  logic                   vblank,
    input  logic                   pal_in,
    input  logic [PHASE_INC_W-1:0] phase_inc_in,
    input  logic [RANGE_W-1:0]     burst_range_in,
    output logic [PHASE_INC_W-1:0] phase_inc,
    output logic                   pal,
    output logic                   cfg_valid,
    output logic                   burst_en,
    output logic                   pal_vswitch,
    output logic                   chroma_active,
    output logic                   line_start,
    output logic                   frame_start
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state, state_nxt;
    logic               hs_edge, vs_edge, vs_lvl;
    logic               snap, run_ok, pal_nxt;
    logic               vsw_base, vsw_nxt;
    logic               line_ok;
    logic [CNT_W-1:0]   cnt;
    logic [RANGE_W-1:0] range_q;
    logic [NTSC_W-1:0]  end_sel;

    yc_sync_edge #(.ACTIVE_HIGH(HS_ACTIVE_HIGH)) u_hs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (hsync),
        .lead    (hs_edge),
        .pulse   (line_start)
    );

    yc_sync_edge #(.ACTIVE_HIGH(VS_ACTIVE_HIGH)) u_vs_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sync_in (vsync),
        .lead    (vs_edge),
        .pulse   (frame_start)
    );

    assign vs_lvl = VS_ACTIVE_HIGH ? vsync : ~vsync;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Disable takes priority over a coincident vsync edge, so no snapshot then.
    always_comb begin
        state_nxt = state;
        snap      = 1'b0;
        case (state)
            IDLE: begin
                if (yc_en) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (!yc_en) begin
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    snap      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!yc_en) begin
                    state_nxt = IDLE;
                end else if (vs_edge) begin
                    snap = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A snapshot lands before the line toggle, so the toggle sees the new standard.
    always_comb begin
        run_ok   = (state == RUN) && yc_en;
        pal_nxt  = snap ? pal_in : pal;
        vsw_base = (snap && (pal_in != pal)) ? 1'b0 : pal_vswitch;
        vsw_nxt  = 1'b0;
        if (run_ok && pal_nxt) begin
            vsw_nxt = hs_edge ? ~vsw_base : vsw_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_inc   <= '0;
            pal         <= 1'b0;
            range_q     <= '0;
            cfg_valid   <= 1'b0;
            cnt         <= '0;
            line_ok     <= 1'b0;
            pal_vswitch <= 1'b0;
        end else begin
            if (snap) begin
                phase_inc <= phase_inc_in;
                pal       <= pal_in;
                range_q   <= burst_range_in;
            end
            cfg_valid <= (state_nxt != IDLE) && (cfg_valid || snap);

            // Saturating, so an over-long line cannot wrap back into the window.
            if ((state == RUN) && hs_edge) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            if (!run_ok) begin
                line_ok <= 1'b0;
            end else if (hs_edge) begin
                line_ok <= !(SUPPRESS_VS_BURST && vs_lvl);
            end

            pal_vswitch <= vsw_nxt;
        end
    end

    always_comb begin
        end_sel  = end_select(range_q, pal);
        burst_en = (state == RUN) && line_ok
                   && (32'(cnt) >= 32'(range_q[START_LSB +: START_W]))
                   && (32'(cnt) < 32'(end_sel));
        chroma_active = (state == RUN) && !hblank && !vblank && cfg_valid;
    end

endmodule
